// File: rtl/cmd_initiator.sv
// Single-outstanding read initiator: issues a device command per host request,
// waits for a rising dev_done (or a cycle timeout) and returns the result.
module cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_index,
    output logic        req_ready,
    output logic [7:0]  cmd,
    input  logic [31:0] dev_result,
    input  logic        dev_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cmd_reg, cmd_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        done_q_reg;
    logic        completion;

    // Only a fresh 0->1 edge of dev_done counts; a level already high is stale.
    assign completion = dev_done & ~done_q_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cmd_reg         <= 8'h00;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= 32'h0;
            rsp_timeout_reg <= 1'b0;
            cnt_reg         <= 8'h00;
            done_q_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_reg         <= cmd_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_timeout_reg <= rsp_timeout_next;
            cnt_reg         <= cnt_next;
            done_q_reg      <= dev_done;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cmd_next         = cmd_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_timeout_next = rsp_timeout_reg;
        cnt_next         = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    // The 4'h8 prefix keeps the command nonzero for index 0.
                    cmd_next   = {4'h8, req_index};
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = 8'h00;
                state_next = WAIT;
            end
            WAIT: begin
                if (completion) begin
                    rsp_data_next    = dev_result;
                    rsp_timeout_next = 1'b0;
                    cmd_next         = 8'h00;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    rsp_data_next    = 32'h0;
                    rsp_timeout_next = 1'b1;
                    cmd_next         = 8'h00;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign cmd         = cmd_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_cmd_initiator.sv
// Directed bench for cmd_initiator with TIMEOUT_CYCLES=8; expected values are
// worked out by hand from the cycle-by-cycle behaviour of the request flow.
module tb_cmd_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_index;
    logic        req_ready;
    logic [7:0]  cmd;
    logic [31:0] dev_result;
    logic        dev_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    cmd_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_index   (req_index),
        .req_ready   (req_ready),
        .cmd         (cmd),
        .dev_result  (dev_result),
        .dev_done    (dev_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        total++;
        if (obs !== exp_val) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one rising edge, then settle so outputs can be sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_index = 4'h0;
        dev_result = 32'h0; dev_done = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_cmd", 32'(cmd), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 0);
        reset = 1'b1;

        // Basic read of index 5, completion edge 3 cycles after acceptance.
        req_valid = 1'b1; req_index = 4'h5;
        tick();
        check("basic_cmd", 32'(cmd), 32'h85);
        check("basic_busy", 32'(busy), 1);
        check("basic_req_ready", 32'(req_ready), 0);
        req_valid = 1'b0; req_index = 4'hF;
        tick();
        check("basic_cmd_hold", 32'(cmd), 32'h85);
        tick();
        dev_result = 32'hDEADBEEF; dev_done = 1'b1;
        tick();
        check("basic_rsp_valid", 32'(rsp_valid), 1);
        check("basic_rsp_data", rsp_data, 32'hDEADBEEF);
        check("basic_rsp_timeout", 32'(rsp_timeout), 0);
        check("basic_cmd_clr", 32'(cmd), 0);
        rsp_ready = 1'b1;
        tick();
        check("basic_hs_valid", 32'(rsp_valid), 0);
        check("basic_hs_busy", 32'(busy), 0);
        rsp_ready = 1'b0; dev_done = 1'b0; dev_result = 32'h12345678;

        // Index 0 with no completion: timeout response 10 cycles after acceptance.
        req_valid = 1'b1; req_index = 4'h0;
        tick();
        check("idx0_cmd", 32'(cmd), 32'h80);
        req_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            tick();
            check($sformatf("idx0_cmd_c%0d", k), 32'(cmd), 32'h80);
            check($sformatf("tmo_novalid_c%0d", k), 32'(rsp_valid), 0);
        end
        tick();
        check("tmo_rsp_valid", 32'(rsp_valid), 1);
        check("tmo_rsp_timeout", 32'(rsp_timeout), 1);
        check("tmo_rsp_data", rsp_data, 0);
        check("tmo_cmd", 32'(cmd), 0);

        // Backpressure: response held for 5 cycles while a new request waits.
        req_valid = 1'b1; req_index = 4'h3;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 1);
            check($sformatf("bp_timeout_%0d", k), 32'(rsp_timeout), 1);
            check($sformatf("bp_data_%0d", k), rsp_data, 0);
            check($sformatf("bp_req_ready_%0d", k), 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        check("bp_req_ready_hs", 32'(req_ready), 0);
        tick();
        rsp_ready = 1'b0;
        check("bp_after_valid", 32'(rsp_valid), 0);
        check("bp_after_req_ready", 32'(req_ready), 1);
        check("bp_after_busy", 32'(busy), 0);
        tick();
        check("bp_accept_cmd", 32'(cmd), 32'h83);
        req_valid = 1'b0;
        tick();
        dev_result = 32'hA5A5A5A5; dev_done = 1'b1;
        tick();
        check("bp_rsp_data", rsp_data, 32'hA5A5A5A5);
        check("bp_rsp_timeout", 32'(rsp_timeout), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Stale level: dev_done stays high, so only the timeout can end the wait.
        req_valid = 1'b1; req_index = 4'h7;
        tick();
        check("stale_cmd", 32'(cmd), 32'h87);
        req_valid = 1'b0;
        for (int k = 2; k <= 9; k++) tick();
        check("stale_novalid_c9", 32'(rsp_valid), 0);
        tick();
        check("stale_rsp_valid", 32'(rsp_valid), 1);
        check("stale_rsp_timeout", 32'(rsp_timeout), 1);
        check("stale_rsp_data", rsp_data, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; dev_done = 1'b0;

        // Completion edge on the threshold cycle: data wins over timeout.
        req_valid = 1'b1; req_index = 4'h9;
        tick();
        req_valid = 1'b0;
        for (int k = 2; k <= 9; k++) tick();
        dev_result = 32'hCAFEF00D; dev_done = 1'b1;
        tick();
        check("race_rsp_valid", 32'(rsp_valid), 1);
        check("race_rsp_timeout", 32'(rsp_timeout), 0);
        check("race_rsp_data", rsp_data, 32'hCAFEF00D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; dev_done = 1'b0;

        // Reset in the middle of WAIT aborts with no response.
        req_valid = 1'b1; req_index = 4'h2;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("mid_busy_pre", 32'(busy), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_cmd", 32'(cmd), 0);
        check("mid_rsp_valid", 32'(rsp_valid), 0);
        check("mid_busy", 32'(busy), 0);
        dev_result = 32'h55AA55AA; dev_done = 1'b1;
        tick();
        dev_done = 1'b0;
        tick(); tick(); tick();
        check("mid_late_valid", 32'(rsp_valid), 0);
        check("mid_late_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
